regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath; next generation of the single-write/dual-read file.
- Configurable width, depth, read-port count and two prioritised write ports. Hardwired zero register is optional.
- Built-in multi-cycle clear sequencer, so software and debug can wipe the file without reset.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, bits per entry
- DEPTH, 32, number of entries (need not be a power of 2)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
- AW, derived = clog2(DEPTH), address width (localparam, not overridable)

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  flattened read addresses; port k at [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
- wr_en  in  2  write enables, ports 0 and 1
- wr_addr  in  2*AW  write addresses
- wr_data  in  2*DATA_W  write data
- clr_req  in  1  start clear sequence (sampled only in IDLE)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async on rst rising, held while high):
  - all entries = 0, rd_data = 0, clr_busy = 0, clr_done = 0
  - FSM = IDLE, clear counter = 0
- Read: latency 1.
  - rd_en[k] high at edge: rd_data[k] <= entry[rd_addr[k]].
  - rd_en[k] low: rd_data[k] holds its value.
  - Ports are independent; any number of ports may read the same address.
- Read returns 0 when:
  - ZERO_REG=1 and address 0, or
  - address >= DEPTH.
- Write:
  - wr_en[j] high at edge writes wr_data[j] to wr_addr[j].
  - Both ports, same address: port 1 wins.
  - Writes are dropped when ZERO_REG=1 and address 0, or when address >= DEPTH.
- Read/write same address, same edge (bypass macro off): read returns the pre-write value.
- Clear FSM:
  - IDLE: clr_req=1 at edge -> CLEAR. Counter=0, clr_busy=1 from next cycle. A write accepted on the same edge as clr_req still takes effect.
  - CLEAR: each edge zeroes entry[counter] and increments counter. All wr_en writes are dropped. Reads proceed normally and return current contents. clr_req is ignored.
  - CLEAR, counter = DEPTH-1: zero the last entry -> DONE.
  - DONE (one cycle): clr_busy=0, clr_done=1 -> IDLE. Writes are accepted in DONE.
  - Total: clr_busy is high for exactly DEPTH cycles.
- rst asserted mid-clear: immediate return to IDLE with full reset values; no clr_done pulse.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If rd_en[k] and rd_addr[k] matches an accepted write this edge, rd_data[k] gets that wr_data (port 1 priority).
  - In CLEAR, a read of the entry being zeroed this edge returns 0.
  - Dropped writes (zero reg, out of range, during CLEAR) are never forwarded.
- Undefined: read-before-write as above; no forwarding mux is synthesised.

Decomposition:
- Package regfile_pkg:
  - state encodings ST_IDLE, ST_CLEAR, ST_DONE
  - clog2 function
  - default DATA_W/DEPTH constants
- Sub-module regfile_clr_seq:
  - owns FSM and counter
  - outputs clr_busy, clr_done, clr_we and clr_addr to the storage array
- Top: storage array, write arbitration, read registers, bypass mux.

Test Plan:
- Reset (defaults): after rst, rd_en=2'b11, rd_addr={5'd7,5'd3} -> rd_data all 0; clr_busy=0, clr_done=0.
- Write/read: write port0 addr 5 = 32'hDEADBEEF; next cycle read port1 addr 5 -> 32'hDEADBEEF one cycle later.
- Write-port priority: same edge port0 addr 9 = 32'h1111, port1 addr 9 = 32'h2222 -> read of 9 returns 32'h2222.
- Zero register: write addr 0 = 32'hFFFFFFFF -> read of 0 returns 0. With ZERO_REG=0 and DEPTH=20, the same write reads back FFFFFFFF; read of addr 25 returns 0.
- Read/write same edge: write addr 4 = 32'hA5A5 while reading addr 4 (old value 32'h1).
  - Bypass undefined -> 32'h1.
  - REGFILE_BYPASS_EN -> 32'hA5A5.
- Clear sequence: fill all 32 entries with their index+1, pulse clr_req.
  - clr_busy high exactly 32 cycles, then one-cycle clr_done.
  - A port-0 write to addr 3 during busy is dropped; all reads afterwards return 0.
  - Repeat with rst asserted at busy cycle 10 -> clr_busy=0 immediately, no clr_done, all entries 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
// Clear-sequencer state encodings, default geometry, ceil-log2 helper.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_st_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: walks every entry once, zeroing one per cycle.
// Busy for exactly DEPTH cycles, then a single-cycle done pulse.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_st_t       st, st_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  // state and walk counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // next state and decoded outputs
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (clr_req) begin
          st_nxt  = ST_CLEAR;
          cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        if (cnt == AW'(DEPTH - 1)) begin
          st_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      ST_DONE: begin
        clr_done = 1'b1;
        st_nxt   = ST_IDLE;
        cnt_nxt  = '0;
      end
      default: begin
        st_nxt  = ST_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-write, NUM_RD-read register file with clear sequencer.
// Optional write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [2*AW-1:0]          wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [1:0]        wr_ok;
  logic [AW-1:0]     ra [NUM_RD];
  logic [DATA_W-1:0] rd_nxt [NUM_RD];
  logic              clr_we;
  logic [AW-1:0]     clr_addr;

  // entries that exist and are writable/readable
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clr_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // unpack write ports; writes are dropped while clearing
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      wa[j]    = wr_addr[j*AW +: AW];
      wd[j]    = wr_data[j*DATA_W +: DATA_W];
      wr_ok[j] = wr_en[j] && !clr_we && addr_ok(wa[j]);
    end
  end

  // storage: clear walk, then port 1 over port 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && clr_addr == AW'(i))
          mem[i] <= '0;
        else if (wr_ok[1] && wa[1] == AW'(i))
          mem[i] <= wd[1];
        else if (wr_ok[0] && wa[0] == AW'(i))
          mem[i] <= wd[0];
      end
    end
  end

  // read lookup, with optional forwarding of this edge's updates
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k]     = rd_addr[k*AW +: AW];
      rd_nxt[k] = '0;
      if (addr_ok(ra[k])) rd_nxt[k] = mem[ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (clr_we && clr_addr == ra[k]) rd_nxt[k] = '0;
      if (wr_ok[0] && wa[0] == ra[k]) rd_nxt[k] = wd[0];
      if (wr_ok[1] && wa[1] == ra[k]) rd_nxt[k] = wd[1];
`endif
    end
  end

  // registered read ports, hold when not enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en[k]) rd_data[k*DATA_W +: DATA_W] <= rd_nxt[k];
      end
    end
  end

endmodule
